flag_branch_unit: RTL and testbench

- Sits directly downstream of the execute-stage ALU.
- Captures the ALU result-derived condition flags (Z, V, N) into the architectural flag register, using per-opcode write masks.
- Evaluates the 3-bit branch condition code of a B/BR instruction in decode and returns taken/not-taken.
- Stalls decode when a branch depends on flags still being produced in EX, and keeps a saturating count of taken branches.

---
 rtl/flag_branch_unit.sv | 192 +++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Flag register and branch-condition resolver sitting behind the EX-stage ALU.
// Optional `FLAG_FWD_EN bypasses same-cycle ALU flags into a dependent branch instead of stalling.
module flag_branch_unit #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_opcode,
  input  logic                 ex_hold,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_ovfl,
  input  logic                 flush,
  input  logic                 br_valid,
  input  logic [2:0]           br_ccc,
  output logic                 br_taken,
  output logic                 br_stall,
  output logic [2:0]           flags,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  typedef enum logic [0:0] {
    EVAL = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_next_s;
  logic [2:0]            flags_r;
  logic [2:0]            flags_next_s;
  logic                  wr_zvn_s;
  logic                  wr_z_s;
  logic                  flag_we_s;
  logic                  flag_dep_s;
  logic                  taken_s;
  logic                  stall_s;
  logic [CNT_WIDTH-1:0]  cnt_r;

  // Branch condition on a {Z,V,N} flag vector.
  function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (ccc)
      3'b000:  cond_eval = ~z;
      3'b001:  cond_eval = z;
      3'b010:  cond_eval = ~z & ~n;
      3'b011:  cond_eval = n;
      3'b100:  cond_eval = z | ~n;
      3'b101:  cond_eval = n | z;
      3'b110:  cond_eval = v;
      3'b111:  cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Per-opcode flag write mask.
  always_comb begin
    wr_zvn_s = 1'b0;
    wr_z_s   = 1'b0;
    case (ex_opcode)
      4'b0000, 4'b0001: begin
        wr_zvn_s = 1'b1;
        wr_z_s   = 1'b1;
      end
      4'b0010, 4'b0100, 4'b0101, 4'b0110: begin
        wr_zvn_s = 1'b0;
        wr_z_s   = 1'b1;
      end
      default: begin
        wr_zvn_s = 1'b0;
        wr_z_s   = 1'b0;
      end
    endcase
  end

  // Z is derived from the full result rather than trusting an ALU zero line.
  assign flags_next_s = {wr_z_s   ? (alu_out == {WIDTH{1'b0}}) : flags_r[2],
                         wr_zvn_s ? alu_ovfl                   : flags_r[1],
                         wr_zvn_s ? alu_out[WIDTH-1]           : flags_r[0]};
  assign flag_dep_s   = ex_valid & wr_z_s;
  assign flag_we_s    = flag_dep_s & ~ex_hold;

  // Architectural flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r <= 3'b000;
    end else if (flag_we_s) begin
      flags_r <= flags_next_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EVAL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = EVAL;
    case (state_r)
      EVAL: begin
        if (~flush & br_valid & flag_dep_s) begin
`ifdef FLAG_FWD_EN
          state_next_s = ex_hold ? WAIT : EVAL;
`else
          state_next_s = WAIT;
`endif
        end else begin
          state_next_s = EVAL;
        end
      end
      WAIT: begin
        if (~flush & br_valid & ex_hold) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = EVAL;
        end
      end
      default: state_next_s = EVAL;
    endcase
  end

  // FSM outputs; both are forced low while reset is asserted.
  always_comb begin
    taken_s = 1'b0;
    stall_s = 1'b0;
    if (rst | flush) begin
      taken_s = 1'b0;
      stall_s = 1'b0;
    end else begin
      case (state_r)
        EVAL: begin
          if (br_valid & flag_dep_s) begin
`ifdef FLAG_FWD_EN
            if (ex_hold) begin
              stall_s = 1'b1;
            end else begin
              taken_s = cond_eval(br_ccc, flags_next_s);
            end
`else
            stall_s = 1'b1;
`endif
          end else begin
            taken_s = br_valid & cond_eval(br_ccc, flags_r);
          end
        end
        WAIT: begin
          if (~br_valid) begin
            taken_s = 1'b0;
          end else if (ex_hold) begin
            stall_s = 1'b1;
          end else begin
            taken_s = cond_eval(br_ccc, flags_r);
          end
        end
        default: begin
          taken_s = 1'b0;
          stall_s = 1'b0;
        end
      endcase
    end
  end

  // Saturating count of taken branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (taken_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign br_taken  = taken_s;
  assign br_stall  = stall_s;
  assign flags     = flags_r;
  assign taken_cnt = cnt_r;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: stimulus pushes model expectations, a negedge monitor checks.
module tb_flag_branch_unit;

  localparam int W = 16;
  localparam int C = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic [3:0]    ex_opcode = 4'h0;
  logic          ex_hold = 1'b0;
  logic [W-1:0]  alu_out = '0;
  logic          alu_ovfl = 1'b0;
  logic          flush = 1'b0;
  logic          br_valid = 1'b0;
  logic [2:0]    br_ccc = 3'b000;
  logic          br_taken;
  logic          br_stall;
  logic [2:0]    flags;
  logic [C-1:0]  taken_cnt;

  typedef struct {
    logic         taken;
    logic         stall;
    logic [2:0]   flg;
    logic [C-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [2:0]   m_flags = 3'b000;
  logic         m_wait  = 1'b0;
  logic [C-1:0] m_cnt   = '0;

  flag_branch_unit #(.WIDTH(W), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_hold(ex_hold), .alu_out(alu_out), .alu_ovfl(alu_ovfl), .flush(flush),
    .br_valid(br_valid), .br_ccc(br_ccc), .br_taken(br_taken),
    .br_stall(br_stall), .flags(flags), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [2:0] cc, input logic [2:0] f);
    case (cc)
      3'd0: return !f[2];
      3'd1: return f[2];
      3'd2: return !f[2] && !f[0];
      3'd3: return f[0];
      3'd4: return f[2] || !f[0];
      3'd5: return f[0] || f[2];
      3'd6: return f[1];
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model and queue its expectation.
  task automatic step(input logic r, input logic ev, input logic [3:0] op, input logic hd,
                      input logic [W-1:0] a, input logic ov, input logic fl,
                      input logic bv, input logic [2:0] cc);
    exp_t e;
    logic wz, wall, dep, tk, st, nw;
    logic [2:0] nf;
    @(posedge clk);
    #1;
    rst = r; ex_valid = ev; ex_opcode = op; ex_hold = hd; alu_out = a;
    alu_ovfl = ov; flush = fl; br_valid = bv; br_ccc = cc;
    wall = (op == 4'd0) || (op == 4'd1);
    wz   = wall || (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    nf   = {wz ? (a == 16'h0000) : m_flags[2], wall ? ov : m_flags[1], wall ? a[W-1] : m_flags[0]};
    dep  = ev && wz;
    tk = 1'b0; st = 1'b0; nw = 1'b0;
    if (r) begin
      e.taken = 1'b0; e.stall = 1'b0; e.flg = 3'b000; e.cnt = '0;
      m_flags = 3'b000; m_wait = 1'b0; m_cnt = '0;
    end else begin
      e.flg = m_flags;
      e.cnt = m_cnt;
      if (fl) begin
        tk = 1'b0;
      end else if (!m_wait) begin
        if (bv && dep) begin
`ifdef FLAG_FWD_EN
          if (hd) begin st = 1'b1; nw = 1'b1; end
          else tk = ref_cond(cc, nf);
`else
          st = 1'b1; nw = 1'b1;
`endif
        end else begin
          tk = bv && ref_cond(cc, m_flags);
        end
      end else begin
        if (bv && hd) begin st = 1'b1; nw = 1'b1; end
        else if (bv) tk = ref_cond(cc, m_flags);
      end
      e.taken = tk;
      e.stall = st;
      if (ev && !hd) m_flags = nf;
      if (tk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_wait = nw;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'hF, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("br_taken",  {31'd0, br_taken}, {31'd0, e.taken});
      chk("br_stall",  {31'd0, br_stall}, {31'd0, e.stall});
      chk("flags",     {29'd0, flags},    {29'd0, e.flg});
      chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.cnt});
    end
  end

  initial begin
    logic [3:0] op;
    logic [W-1:0] a;
    step(1'b1, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd7);
    idle();
    // ADD zero result, then BEQ with no dependency.
    step(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1);
    idle();
    // SUB sets V,N; XOR only touches Z; OVFL branch.
    step(1'b0, 1'b1, 4'h1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 4'h2, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd6);
    idle();
    // Dependent BLT behind SUB.
    step(1'b0, 1'b1, 4'h1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3);
    idle();
    // Dependent branch held in WAIT for three cycles.
    step(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 4'h1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b0, 4'h1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1, 3'd1);
    idle();
    // Flush while in WAIT.
    step(1'b0, 1'b1, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd7);
    step(1'b0, 1'b1, 4'h2, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd7);
    step(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd7);
    // Reset while stalled.
    step(1'b0, 1'b1, 4'h1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 3'd3);
    step(1'b1, 1'b1, 4'h1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 3'd3);
    idle();
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      a  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), op,
           ($urandom_range(0, 4) == 0), a, 1'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) < 3), 3'($urandom_range(0, 7)));
    end
    // Saturate the taken counter with unconditional branches.
    for (int i = 0; i < 65540; i++)
      step(1'b0, 1'b0, 4'hF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 3'd7);
    idle();
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("cnt_saturated", {16'd0, taken_cnt}, 32'h0000FFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
